// File: rtl/ipmxb_qsgmii_hsst_pll_powerup_v1_0_if.sv
// rtl/ipmxb_qsgmii_hsst_pll_powerup_v1_0_if.sv - HSST PLL control/status pins
// master = power-up sequencer, slave = HSST PLL.
interface ipmxb_qsgmii_hsst_pll_powerup_v1_0_if;
  logic P_PLLPOWERDOWN;
  logic P_PLL_RST;
  logic P_PLL_READY;

  modport master (
    output P_PLLPOWERDOWN,
    output P_PLL_RST,
    input  P_PLL_READY
  );

  modport slave (
    input  P_PLLPOWERDOWN,
    input  P_PLL_RST,
    output P_PLL_READY
  );
endinterface

// File: rtl/ipmxb_qsgmii_hsst_pll_powerup_v1_0.sv
// rtl/ipmxb_qsgmii_hsst_pll_powerup_v1_0.sv - HSST PLL power-up/reset sequencer
// Power-down, reset, filtered lock wait, retry on timeout or lock loss.
module ipmxb_qsgmii_hsst_pll_powerup_v1_0 #(
  parameter int FREE_CLOCK_FREQ = 100,
  parameter int PD_TIME_US      = 40,
  parameter int RST_TIME_US     = 41,
  parameter int LOCK_TIMEOUT_US = 1000,
  parameter int LOCK_FILTER     = 64,
  parameter int CNTR_WIDTH      = 18
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     i_pll_rst,
  ipmxb_qsgmii_hsst_pll_powerup_v1_0_if.master     hsst,
  output logic                                     o_pll_done,
  output logic                                     o_pll_lock_lost,
  output logic [3:0]                               o_retry_cnt
);

  localparam int FW = (LOCK_FILTER > 1) ? $clog2(LOCK_FILTER) : 1;
  localparam logic [CNTR_WIDTH-1:0] PD_LAST  = CNTR_WIDTH'(PD_TIME_US * FREE_CLOCK_FREQ - 1);
  localparam logic [CNTR_WIDTH-1:0] RST_LAST = CNTR_WIDTH'(RST_TIME_US * FREE_CLOCK_FREQ - 1);
  localparam logic [CNTR_WIDTH-1:0] TO_LAST  = CNTR_WIDTH'(LOCK_TIMEOUT_US * FREE_CLOCK_FREQ - 1);
  localparam logic [FW-1:0]         F_LAST   = FW'(LOCK_FILTER - 1);

  typedef enum logic [1:0] {S_PD, S_RST, S_WAIT, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [CNTR_WIDTH-1:0] timer_q, timer_d;
  logic [FW-1:0]         fcnt_q, fcnt_d;
  logic [1:0]            req_sync_q, req_sync_d;
  logic [1:0]            rdy_sync_q, rdy_sync_d;
  logic                  pd_q, pd_d;
  logic                  prst_q, prst_d;
  logic                  done_q, done_d;
  logic                  lost_q, lost_d;
  logic [3:0]            retry_q, retry_d;
  logic                  rst_req_s, ready_s;
  logic [3:0]            retry_inc;

  assign rst_req_s = req_sync_q[1];
  assign ready_s   = rdy_sync_q[1];
  assign retry_inc = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;

  always_comb begin
    req_sync_d = {req_sync_q[0], i_pll_rst};
    rdy_sync_d = {rdy_sync_q[0], hsst.P_PLL_READY};
    state_d    = state_q;
    timer_d    = timer_q;
    fcnt_d     = fcnt_q;
    pd_d       = pd_q;
    prst_d     = prst_q;
    done_d     = done_q;
    lost_d     = 1'b0;
    retry_d    = retry_q;

    // User re-initialisation overrides every other transition and parks in S_PD.
    if (rst_req_s) begin
      state_d = S_PD;
      timer_d = '0;
      fcnt_d  = '0;
      pd_d    = 1'b1;
      prst_d  = 1'b1;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        S_PD: begin
          if (timer_q == PD_LAST) begin
            timer_d = '0;
            state_d = S_RST;
            pd_d    = 1'b0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        S_RST: begin
          if (timer_q == RST_LAST) begin
            timer_d = '0;
            state_d = S_WAIT;
            prst_d  = 1'b0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        S_WAIT: begin
          fcnt_d  = ready_s ? fcnt_q + 1'b1 : '0;
          timer_d = timer_q + 1'b1;
          // A lock completing on the timeout cycle still counts as locked.
          if (ready_s && (fcnt_q == F_LAST)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            fcnt_d  = '0;
            timer_d = '0;
          end else if (timer_q == TO_LAST) begin
            state_d = S_RST;
            prst_d  = 1'b1;
            timer_d = '0;
            fcnt_d  = '0;
            retry_d = retry_inc;
          end
        end
        S_DONE: begin
          if (!ready_s) begin
            state_d = S_RST;
            done_d  = 1'b0;
            lost_d  = 1'b1;
            prst_d  = 1'b1;
            timer_d = '0;
            fcnt_d  = '0;
            retry_d = retry_inc;
          end
        end
        default: begin
          state_d = S_PD;
          timer_d = '0;
          pd_d    = 1'b1;
          prst_d  = 1'b1;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_PD;
      timer_q    <= '0;
      fcnt_q     <= '0;
      req_sync_q <= '0;
      rdy_sync_q <= '0;
      pd_q       <= 1'b1;
      prst_q     <= 1'b1;
      done_q     <= 1'b0;
      lost_q     <= 1'b0;
      retry_q    <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      fcnt_q     <= fcnt_d;
      req_sync_q <= req_sync_d;
      rdy_sync_q <= rdy_sync_d;
      pd_q       <= pd_d;
      prst_q     <= prst_d;
      done_q     <= done_d;
      lost_q     <= lost_d;
      retry_q    <= retry_d;
    end
  end

  assign hsst.P_PLLPOWERDOWN = pd_q;
  assign hsst.P_PLL_RST      = prst_q;
  assign o_pll_done          = done_q;
  assign o_pll_lock_lost     = lost_q;
  assign o_retry_cnt         = retry_q;

endmodule
